id_ex_stage: RTL and testbench

ID/EX pipeline register with operand forwarding and load-use hazard detection for the 5-stage MIPS pipeline. It captures decoded instruction fields from ID on each clock and drives the EX-stage ALU inputs: `in1`, `in2`, `ALUCt`, `Sign` and `shamt`. Operands are corrected in EX using results forwarded from EX/MEM and MEM/WB. It also raises a stall request toward IF/ID when a load in EX feeds the instruction currently in ID.

---
 rtl/id_ex_stage.sv | 217 +++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register for the 5-stage MIPS pipeline.
// Captures decoded ID fields each clock and drives the EX-stage ALU operands.
// Also raises a combinational load-use stall request toward IF/ID.
//
// Build option:
//   IDEX_FORWARD_EN defined   - operands are forwarded from EX/MEM (first
//                               priority) and MEM/WB. Only a load in EX
//                               stalls the instruction in ID.
//   IDEX_FORWARD_EN undefined - no forwarding. Operands come from the
//                               register file only. Any RAW hazard against
//                               EX or EX/MEM stalls. WB-stage hazards rely on
//                               the register file's write-before-read.
module id_ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [4:0]  id_rs_addr,
    input  logic [4:0]  id_rt_addr,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_shamt,
    input  logic        id_shamt_var,
    input  logic        id_alusrc,
    input  logic [4:0]  id_aluct,
    input  logic        id_sign,
    input  logic [4:0]  id_rd,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        id_memwrite,
    input  logic        id_memtoreg,
    input  logic        exmem_regwrite,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_regwrite,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_result,
    output logic [31:0] ex_in1,
    output logic [31:0] ex_in2,
    output logic [4:0]  ex_aluct,
    output logic [4:0]  ex_shamt,
    output logic        ex_sign,
    output logic [31:0] ex_store_data,
    output logic        ex_valid,
    output logic        ex_regwrite,
    output logic        ex_memread,
    output logic        ex_memwrite,
    output logic        ex_memtoreg,
    output logic [4:0]  ex_rd,
    output logic [1:0]  ex_fwd_a,
    output logic [1:0]  ex_fwd_b,
    output logic        load_use_stall
);

    // Registered ID/EX fields
    logic        r_valid;
    logic [4:0]  r_rs_addr;
    logic [4:0]  r_rt_addr;
    logic [31:0] r_rs_data;
    logic [31:0] r_rt_data;
    logic [31:0] r_imm;
    logic [4:0]  r_shamt;
    logic        r_shamt_var;
    logic        r_alusrc;
    logic [4:0]  r_aluct;
    logic        r_sign;
    logic [4:0]  r_rd;
    logic        r_regwrite;
    logic        r_memread;
    logic        r_memwrite;
    logic        r_memtoreg;

    // Next-state values and control
    logic        w_load;
    logic        w_capture;
    logic        w_ctl_en;
    logic        w_stall;
    logic        w_rs_hit_ex;
    logic        w_rt_hit_ex;
    logic [1:0]  w_fwd_a;
    logic [1:0]  w_fwd_b;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;

    // Register load policy: flush wins over hold, hold wins over the stall
    // bubble. A bubble is simply a capture of all zeros.
    always_comb begin
        w_load    = flush | ~hold;
        w_capture = ~flush & ~hold & ~w_stall;
        w_ctl_en  = w_capture & id_valid;
    end

    // Pipeline register: reset, then flush/hold/stall/capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_rs_addr   <= '0;
            r_rt_addr   <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_shamt     <= '0;
            r_shamt_var <= 1'b0;
            r_alusrc    <= 1'b0;
            r_aluct     <= '0;
            r_sign      <= 1'b0;
            r_rd        <= '0;
            r_regwrite  <= 1'b0;
            r_memread   <= 1'b0;
            r_memwrite  <= 1'b0;
            r_memtoreg  <= 1'b0;
        end else if (w_load) begin
            r_valid     <= w_ctl_en & id_valid;
            r_rs_addr   <= w_capture ? id_rs_addr   : '0;
            r_rt_addr   <= w_capture ? id_rt_addr   : '0;
            r_rs_data   <= w_capture ? id_rs_data   : '0;
            r_rt_data   <= w_capture ? id_rt_data   : '0;
            r_imm       <= w_capture ? id_imm       : '0;
            r_shamt     <= w_capture ? id_shamt     : '0;
            r_shamt_var <= w_capture & id_shamt_var;
            r_alusrc    <= w_capture & id_alusrc;
            r_aluct     <= w_capture ? id_aluct     : '0;
            r_sign      <= w_capture & id_sign;
            r_rd        <= w_capture ? id_rd        : '0;
            r_regwrite  <= w_ctl_en & id_regwrite;
            r_memread   <= w_ctl_en & id_memread;
            r_memwrite  <= w_ctl_en & id_memwrite;
            r_memtoreg  <= w_ctl_en & id_memtoreg;
        end
    end

    // Does the instruction in EX write a register that ID is reading?
    always_comb begin
        w_rs_hit_ex = (r_rd != 5'd0) && (r_rd == id_rs_addr);
        w_rt_hit_ex = (r_rd != 5'd0) && (r_rd == id_rt_addr);
    end

`ifdef IDEX_FORWARD_EN
    // Forward select: EX/MEM first, then MEM/WB; $0 never forwards
    always_comb begin
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == r_rs_addr))
            w_fwd_a = 2'b10;
        else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == r_rs_addr))
            w_fwd_a = 2'b01;
        if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == r_rt_addr))
            w_fwd_b = 2'b10;
        else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == r_rt_addr))
            w_fwd_b = 2'b01;
    end

    // Operand muxes driven by the forward selects
    always_comb begin
        w_rs_val = r_rs_data;
        w_rt_val = r_rt_data;
        case (w_fwd_a)
            2'b10:   w_rs_val = exmem_result;
            2'b01:   w_rs_val = memwb_result;
            default: w_rs_val = r_rs_data;
        endcase
        case (w_fwd_b)
            2'b10:   w_rt_val = exmem_result;
            2'b01:   w_rt_val = memwb_result;
            default: w_rt_val = r_rt_data;
        endcase
    end

    // Only a load in EX cannot be forwarded in time: one bubble covers it
    always_comb begin
        w_stall = id_valid & r_valid & r_memread & (w_rs_hit_ex | w_rt_hit_ex);
    end
`else
    // No forwarding: operands straight from the register file
    always_comb begin
        w_fwd_a  = 2'b00;
        w_fwd_b  = 2'b00;
        w_rs_val = r_rs_data;
        w_rt_val = r_rt_data;
    end

    // Any RAW hazard against EX or EX/MEM holds ID until the producer
    // reaches WB, where the register file's write-before-read resolves it
    always_comb begin
        w_stall = 1'b0;
        if (id_valid) begin
            if (r_valid && r_regwrite && (w_rs_hit_ex || w_rt_hit_ex))
                w_stall = 1'b1;
            if (exmem_regwrite && (exmem_rd != 5'd0) &&
                ((exmem_rd == id_rs_addr) || (exmem_rd == id_rt_addr)))
                w_stall = 1'b1;
        end
    end
`endif

    // EX-stage output assembly
    always_comb begin
        ex_in1         = w_rs_val;
        ex_in2         = r_alusrc ? r_imm : w_rt_val;
        ex_store_data  = w_rt_val;
        ex_shamt       = r_shamt_var ? w_rs_val[4:0] : r_shamt;
        ex_aluct       = r_aluct;
        ex_sign        = r_sign;
        ex_valid       = r_valid;
        ex_regwrite    = r_regwrite;
        ex_memread     = r_memread;
        ex_memwrite    = r_memwrite;
        ex_memtoreg    = r_memtoreg;
        ex_rd          = r_rd;
        ex_fwd_a       = w_fwd_a;
        ex_fwd_b       = w_fwd_b;
        load_use_stall = w_stall;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage. Expected values follow the build
// option IDEX_FORWARD_EN (forwarding) or its absence (register file only).
module tb_id_ex_stage;

`ifdef IDEX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, hold, flush, id_valid;
    logic [4:0]  id_rs_addr, id_rt_addr, id_shamt, id_aluct, id_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        id_shamt_var, id_alusrc, id_sign;
    logic        id_regwrite, id_memread, id_memwrite, id_memtoreg;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] ex_in1, ex_in2, ex_store_data;
    logic [4:0]  ex_aluct, ex_shamt, ex_rd;
    logic        ex_sign, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
    logic [1:0]  ex_fwd_a, ex_fwd_b;
    logic        load_use_stall;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_shamt(id_shamt), .id_shamt_var(id_shamt_var), .id_alusrc(id_alusrc),
        .id_aluct(id_aluct), .id_sign(id_sign), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .ex_in1(ex_in1), .ex_in2(ex_in2), .ex_aluct(ex_aluct), .ex_shamt(ex_shamt),
        .ex_sign(ex_sign), .ex_store_data(ex_store_data), .ex_valid(ex_valid),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_memtoreg(ex_memtoreg), .ex_rd(ex_rd), .ex_fwd_a(ex_fwd_a),
        .ex_fwd_b(ex_fwd_b), .load_use_stall(load_use_stall)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [31:0] rsd, input logic [31:0] rtd,
                            input logic [31:0] imm, input logic [4:0] sh,
                            input logic shv, input logic asrc, input logic [4:0] act,
                            input logic sg, input logic [4:0] rd, input logic rw,
                            input logic mr, input logic mw, input logic mtr);
        id_valid = v; id_rs_addr = rs; id_rt_addr = rt; id_rs_data = rsd;
        id_rt_data = rtd; id_imm = imm; id_shamt = sh; id_shamt_var = shv;
        id_alusrc = asrc; id_aluct = act; id_sign = sg; id_rd = rd;
        id_regwrite = rw; id_memread = mr; id_memwrite = mw; id_memtoreg = mtr;
    endtask

    task automatic id_idle;
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic clr_wb;
        exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
        memwb_regwrite = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    task automatic test_reset;
        hold = $urandom_range(0, 1); flush = $urandom_range(0, 1);
        drive_id($urandom_range(0, 1), 5'($urandom), 5'($urandom), $urandom, $urandom,
                 $urandom, 5'($urandom), $urandom_range(0, 1), $urandom_range(0, 1),
                 5'($urandom), $urandom_range(0, 1), 5'($urandom), 1, 1, 1, 1);
        exmem_regwrite = 0; exmem_rd = 5'($urandom); exmem_result = $urandom;
        memwb_regwrite = 0; memwb_rd = 5'($urandom); memwb_result = $urandom;
        reset = 1;
        tick; tick;
        total_cnt++; if (ex_in1 !== 32'h0) $display("FAIL rst_in1: got %h want 0", ex_in1); else pass_cnt++;
        total_cnt++; if (ex_in2 !== 32'h0) $display("FAIL rst_in2: got %h want 0", ex_in2); else pass_cnt++;
        total_cnt++; if (ex_store_data !== 32'h0) $display("FAIL rst_store: got %h want 0", ex_store_data); else pass_cnt++;
        total_cnt++; if ({ex_aluct, ex_shamt, ex_rd} !== 15'h0) $display("FAIL rst_fields: got %h want 0", {ex_aluct, ex_shamt, ex_rd}); else pass_cnt++;
        total_cnt++; if ({ex_sign, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg} !== 6'h0)
            $display("FAIL rst_ctl: got %b want 000000", {ex_sign, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg}); else pass_cnt++;
        total_cnt++; if ({ex_fwd_a, ex_fwd_b} !== 4'b0000) $display("FAIL rst_fwd: got %b want 0000", {ex_fwd_a, ex_fwd_b}); else pass_cnt++;
        total_cnt++; if (load_use_stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", load_use_stall); else pass_cnt++;
        reset = 0; hold = 0; flush = 0;
        id_idle; clr_wb;
        tick;
    endtask

    task automatic test_double_forward;
        // addu $6, $3, $4 enters EX
        drive_id(1, 3, 4, 32'h99, 32'h44, 0, 0, 0, 0, 5'h01, 0, 6, 1, 0, 0, 0);
        tick;
        id_idle;
        exmem_regwrite = 1; exmem_rd = 3; exmem_result = 32'h11;
        memwb_regwrite = 1; memwb_rd = 3; memwb_result = 32'h22;
        #1;
        total_cnt++; if (ex_in1 !== (FWD ? 32'h11 : 32'h99)) $display("FAIL dfwd_in1: got %h want %h", ex_in1, FWD ? 32'h11 : 32'h99); else pass_cnt++;
        total_cnt++; if (ex_fwd_a !== (FWD ? 2'b10 : 2'b00)) $display("FAIL dfwd_sel_a: got %b want %b", ex_fwd_a, FWD ? 2'b10 : 2'b00); else pass_cnt++;
        total_cnt++; if (ex_in2 !== 32'h44) $display("FAIL dfwd_in2: got %h want 44", ex_in2); else pass_cnt++;
        total_cnt++; if ({ex_valid, ex_regwrite, ex_rd, ex_aluct} !== {1'b1, 1'b1, 5'd6, 5'h01})
            $display("FAIL dfwd_ctl: got %h want %h", {ex_valid, ex_regwrite, ex_rd, ex_aluct}, {1'b1, 1'b1, 5'd6, 5'h01}); else pass_cnt++;
        exmem_regwrite = 0;
        #1;
        total_cnt++; if (ex_in1 !== (FWD ? 32'h22 : 32'h99)) $display("FAIL wbfwd_in1: got %h want %h", ex_in1, FWD ? 32'h22 : 32'h99); else pass_cnt++;
        total_cnt++; if (ex_fwd_a !== (FWD ? 2'b01 : 2'b00)) $display("FAIL wbfwd_sel_a: got %b want %b", ex_fwd_a, FWD ? 2'b01 : 2'b00); else pass_cnt++;
        clr_wb;
    endtask

    task automatic test_imm_rt_forward;
        // sw-like: rs=1, rt=5, alusrc with imm=4
        drive_id(1, 1, 5, 32'h7, 32'h55, 32'h4, 0, 0, 1, 5'h02, 0, 0, 0, 0, 1, 0);
        tick;
        id_idle;
        memwb_regwrite = 1; memwb_rd = 5; memwb_result = 32'hABCD;
        #1;
        total_cnt++; if (ex_in2 !== 32'h4) $display("FAIL imm_in2: got %h want 4", ex_in2); else pass_cnt++;
        total_cnt++; if (ex_store_data !== (FWD ? 32'hABCD : 32'h55)) $display("FAIL imm_store: got %h want %h", ex_store_data, FWD ? 32'hABCD : 32'h55); else pass_cnt++;
        total_cnt++; if (ex_fwd_b !== (FWD ? 2'b01 : 2'b00)) $display("FAIL imm_sel_b: got %b want %b", ex_fwd_b, FWD ? 2'b01 : 2'b00); else pass_cnt++;
        total_cnt++; if ({ex_in1, ex_memwrite} !== {32'h7, 1'b1}) $display("FAIL imm_in1_mw: got %h want %h", {ex_in1, ex_memwrite}, {32'h7, 1'b1}); else pass_cnt++;
        clr_wb;
    endtask

    task automatic test_shift_var;
        // srav with rs=4: shift amount from (forwarded) rs[4:0]
        drive_id(1, 4, 2, 32'h1F3, 32'h80, 0, 5'd7, 1, 0, 5'h0C, 1, 9, 1, 0, 0, 0);
        tick;
        id_idle;
        memwb_regwrite = 1; memwb_rd = 4; memwb_result = 32'h25;
        #1;
        total_cnt++; if (ex_shamt !== (FWD ? 5'h05 : 5'h13)) $display("FAIL shv_shamt: got %h want %h", ex_shamt, FWD ? 5'h05 : 5'h13); else pass_cnt++;
        total_cnt++; if ({ex_aluct, ex_sign} !== {5'h0C, 1'b1}) $display("FAIL shv_act_sign: got %h want %h", {ex_aluct, ex_sign}, {5'h0C, 1'b1}); else pass_cnt++;
        clr_wb;
        // fixed shamt, and control bits dropped when id_valid=0
        drive_id(0, 4, 2, 32'h1F3, 32'h80, 0, 5'd7, 0, 0, 5'h0C, 0, 9, 1, 1, 1, 1);
        tick;
        id_idle;
        #1;
        total_cnt++; if (ex_shamt !== 5'd7) $display("FAIL sh_fixed: got %h want 7", ex_shamt); else pass_cnt++;
        total_cnt++; if ({ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg} !== 5'b0)
            $display("FAIL inval_ctl: got %b want 00000", {ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg}); else pass_cnt++;
    endtask

    task automatic test_load_use;
        clr_wb;
        // lw $8, 0x10($2)
        drive_id(1, 2, 0, 32'h100, 0, 32'h10, 0, 0, 1, 5'h02, 0, 8, 1, 1, 0, 1);
        tick;
        // addu $10, $8, $9 in ID, stale $8
        drive_id(1, 8, 9, 32'hDEAD, 32'h9, 0, 0, 0, 0, 5'h01, 0, 10, 1, 0, 0, 0);
        #1;
        total_cnt++; if (load_use_stall !== 1'b1) $display("FAIL lu_stall: got %b want 1", load_use_stall); else pass_cnt++;
        tick;
        exmem_regwrite = 1; exmem_rd = 8; exmem_result = 32'h110;
        #1;
        total_cnt++; if (ex_valid !== 1'b0) $display("FAIL lu_bubble: got %b want 0", ex_valid); else pass_cnt++;
`ifdef IDEX_FORWARD_EN
        total_cnt++; if (load_use_stall !== 1'b0) $display("FAIL lu_release: got %b want 0", load_use_stall); else pass_cnt++;
        tick;
        exmem_regwrite = 0;
        memwb_regwrite = 1; memwb_rd = 8; memwb_result = 32'h1234;
        id_idle;
        #1;
        total_cnt++; if (ex_in1 !== 32'h1234) $display("FAIL lu_in1: got %h want 1234", ex_in1); else pass_cnt++;
        total_cnt++; if ({ex_fwd_a, ex_valid} !== {2'b01, 1'b1}) $display("FAIL lu_sel: got %b want 011", {ex_fwd_a, ex_valid}); else pass_cnt++;
`else
        total_cnt++; if (load_use_stall !== 1'b1) $display("FAIL raw_stall2: got %b want 1", load_use_stall); else pass_cnt++;
        tick;
        exmem_regwrite = 0;
        memwb_regwrite = 1; memwb_rd = 8; memwb_result = 32'h1234;
        id_rs_data = 32'h1234;
        #1;
        total_cnt++; if ({ex_valid, load_use_stall} !== 2'b00) $display("FAIL raw_release: got %b want 00", {ex_valid, load_use_stall}); else pass_cnt++;
        tick;
        memwb_regwrite = 0;
        id_idle;
        #1;
        total_cnt++; if (ex_in1 !== 32'h1234) $display("FAIL lu_in1: got %h want 1234", ex_in1); else pass_cnt++;
        total_cnt++; if ({ex_fwd_a, ex_valid} !== {2'b00, 1'b1}) $display("FAIL lu_sel: got %b want 001", {ex_fwd_a, ex_valid}); else pass_cnt++;
`endif
        clr_wb;
    endtask

    task automatic test_reg_zero;
        // load into $0 sits in EX
        drive_id(1, 0, 0, 0, 0, 32'h8, 0, 0, 1, 5'h02, 0, 0, 1, 1, 0, 1);
        tick;
        drive_id(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'h01, 0, 4, 1, 0, 0, 0);
        exmem_regwrite = 1; exmem_rd = 0; exmem_result = 32'hFFFF;
        memwb_regwrite = 1; memwb_rd = 0; memwb_result = 32'hEEEE;
        #1;
        total_cnt++; if (load_use_stall !== 1'b0) $display("FAIL r0_stall: got %b want 0", load_use_stall); else pass_cnt++;
        tick;
        id_idle;
        #1;
        total_cnt++; if (ex_in1 !== 32'h0) $display("FAIL r0_in1: got %h want 0", ex_in1); else pass_cnt++;
        total_cnt++; if ({ex_fwd_a, ex_fwd_b} !== 4'b0000) $display("FAIL r0_fwd: got %b want 0000", {ex_fwd_a, ex_fwd_b}); else pass_cnt++;
        total_cnt++; if ({ex_valid, ex_rd} !== {1'b1, 5'd4}) $display("FAIL r0_adv: got %h want %h", {ex_valid, ex_rd}, {1'b1, 5'd4}); else pass_cnt++;
        clr_wb;
    endtask

    task automatic test_flush_hold;
        drive_id(1, 1, 2, 32'h5, 32'h6, 0, 0, 0, 0, 5'h03, 0, 7, 1, 0, 0, 0);
        tick;
        drive_id(1, 3, 0, 32'h77, 0, 0, 0, 0, 0, 5'h04, 0, 9, 1, 0, 0, 0);
        hold = 1;
        for (int unsigned i = 0; i < 3; i++) begin
            tick;
            total_cnt++; if ({ex_in1, ex_rd, ex_aluct, ex_valid} !== {32'h5, 5'd7, 5'h03, 1'b1})
                $display("FAIL hold_keep%0d: got %h want %h", i, {ex_in1, ex_rd, ex_aluct, ex_valid}, {32'h5, 5'd7, 5'h03, 1'b1}); else pass_cnt++;
        end
        flush = 1;
        tick;
        total_cnt++; if ({ex_valid, ex_regwrite, ex_rd} !== 7'b0) $display("FAIL flush_hold: got %h want 0", {ex_valid, ex_regwrite, ex_rd}); else pass_cnt++;
        flush = 0; hold = 0;
        // hold with a load-use hazard pending
        drive_id(1, 2, 0, 32'h100, 0, 32'h10, 0, 0, 1, 5'h02, 0, 8, 1, 1, 0, 1);
        tick;
        drive_id(1, 8, 0, 32'hDEAD, 0, 0, 0, 0, 0, 5'h01, 0, 10, 1, 0, 0, 0);
        hold = 1;
        tick;
        total_cnt++; if ({ex_memread, ex_rd, load_use_stall} !== {1'b1, 5'd8, 1'b1})
            $display("FAIL hold_hazard: got %h want %h", {ex_memread, ex_rd, load_use_stall}, {1'b1, 5'd8, 1'b1}); else pass_cnt++;
        flush = 1;
        tick;
        total_cnt++; if ({ex_valid, ex_memread, load_use_stall} !== 3'b000)
            $display("FAIL flush_hazard: got %b want 000", {ex_valid, ex_memread, load_use_stall}); else pass_cnt++;
        flush = 0; hold = 0;
        // reset mid-stream
        drive_id(1, 1, 0, 32'h3, 0, 0, 0, 0, 0, 5'h01, 0, 5, 1, 0, 0, 0);
        tick;
        total_cnt++; if ({ex_valid, ex_rd} !== {1'b1, 5'd5}) $display("FAIL pre_rst: got %h want %h", {ex_valid, ex_rd}, {1'b1, 5'd5}); else pass_cnt++;
        reset = 1;
        tick;
        total_cnt++; if ({ex_valid, ex_rd, ex_in1} !== 38'h0) $display("FAIL mid_rst: got %h want 0", {ex_valid, ex_rd, ex_in1}); else pass_cnt++;
        reset = 0;
        id_idle;
    endtask

    initial begin
        reset = 1; hold = 0; flush = 0;
        id_idle; clr_wb;
        #1;
        test_reset;
        test_double_forward;
        test_imm_rt_forward;
        test_shift_var;
        test_load_use;
        test_reg_zero;
        test_flush_hold;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
